// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command decoder and register file sequencing the spi_slave byte datapath.
// Build option: define SPI_REG_CTRL_AUTOINC_EN for burst address auto-increment.
module spi_reg_ctrl #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cs,
    input  logic [7:0]            si_data,
    input  logic                  si_done,
    input  logic                  so_ready,
    output logic [7:0]            so_data,
    output logic                  so_start,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_pulse,
    output logic [ADDR_W-1:0]     wr_addr
);

`ifdef SPI_REG_CTRL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD_LOAD,
        RD_WAIT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        regs [NUM_REGS];
    logic              cs_meta;
    logic              cs_sync;
    logic              cs_prev;
    logic              cs_fall_c;
    logic              cs_rise_c;
    logic              mapped_c;
    logic [7:0]        rd_byte_c;
    logic [ADDR_W-1:0] addr_next_c;

    // Two-flop synchronizer on the raw chip-select pin plus an edge-detect stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta <= 1'b1;
            cs_sync <= 1'b1;
            cs_prev <= 1'b1;
        end else begin
            cs_meta <= cs;
            cs_sync <= cs_meta;
            cs_prev <= cs_sync;
        end
    end

    assign cs_fall_c   = cs_prev & ~cs_sync;
    assign cs_rise_c   = ~cs_prev & cs_sync;
    assign mapped_c    = {1'b0, addr} < NUM_REGS_W;
    assign addr_next_c = !AUTOINC ? addr :
                         (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);

    // Unmapped addresses match no register, so the read mux returns zero for them.
    always_comb begin
        rd_byte_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                rd_byte_c = regs[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr     <= '0;
            so_data  <= '0;
            so_start <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            so_start <= 1'b0;
            wr_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs_fall_c) begin
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (si_done) begin
                        addr  <= si_data[ADDR_W-1:0];
                        state <= si_data[7] ? RD_LOAD : WR;
                    end
                end
                WR: begin
                    if (si_done) begin
                        if (mapped_c) begin
                            wr_pulse <= 1'b1;
                            wr_addr  <= addr;
                        end
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (addr == ADDR_W'(i)) begin
                                regs[i] <= si_data;
                            end
                        end
                        addr <= addr_next_c;
                    end
                end
                RD_LOAD: begin
                    // A byte arriving before so_ready still counts as consumed.
                    if (si_done) begin
                        addr <= addr_next_c;
                    end else if (so_ready && !cs_rise_c) begin
                        so_data  <= rd_byte_c;
                        so_start <= 1'b1;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (si_done) begin
                        addr  <= addr_next_c;
                        state <= RD_LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
            // Deselect wins over any transition above; a same-cycle byte is still applied.
            if (cs_rise_c) begin
                state <= IDLE;
            end
        end
    end

endmodule
